// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD bypassed read ports,
// hardware clear sequencer. Define REGFILE_SCOREBOARD_EN to add busy-bit hazard tracking.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_100MHz,
  input  logic                       arst_n,
  input  logic                       clr_req_i,
  output logic                       ready_o,
  input  logic                       w0_ena_i,
  input  logic [ADDR_W-1:0]          w0_addr_i,
  input  logic [DATA_W-1:0]          w0_data_i,
  input  logic                       w1_ena_i,
  input  logic [ADDR_W-1:0]          w1_addr_i,
  input  logic [DATA_W-1:0]          w1_data_i,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   r_data_o,
  input  logic                       iss_ena_i,
  input  logic [ADDR_W-1:0]          iss_addr_i,
  output logic [NUM_RD-1:0]          busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic run;
  logic w0_we_d;
  logic w1_we_d;

  assign run     = (state_q == RUN);
  assign w0_we_d = run && w0_ena_i && (w0_addr_i != '0);
  assign w1_we_d = run && w1_ena_i && (w1_addr_i != '0);
  assign ready_o = ready_q;

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (clr_req_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // The array is wiped by the sequencer, so it carries no reset; w1 is last and wins.
  always_ff @(posedge clk_100MHz) begin
    if (!run) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      if (w0_we_d) mem_q[w0_addr_i] <= w0_data_i;
      if (w1_we_d) mem_q[w1_addr_i] <= w1_data_i;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= '0;
    end else if (run) begin
      if (clr_req_i) begin
        busy_q <= '0;
      end else begin
        if (w0_we_d) busy_q[w0_addr_i] <= 1'b0;
        if (w1_we_d) busy_q[w1_addr_i] <= 1'b0;
        if (iss_ena_i && (iss_addr_i != '0)) busy_q[iss_addr_i] <= 1'b1;
      end
    end
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_ena_i, iss_addr_i};
  assign busy_o     = '0;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd;

    assign ra   = r_addr_i[k*ADDR_W +: ADDR_W];
    assign hit0 = w0_we_d && (w0_addr_i == ra);
    assign hit1 = w1_we_d && (w1_addr_i == ra);

    always_comb begin
      rd = '0;
      if (run && (ra != '0)) begin
        if (hit1)      rd = w1_data_i;
        else if (hit0) rd = w0_data_i;
        else           rd = mem_q[ra];
      end
    end

    assign r_data_o[k*DATA_W +: DATA_W] = rd;

`ifdef REGFILE_SCOREBOARD_EN
    // A bypassed write resolves the hazard this cycle even though the bit is still set.
    assign busy_o[k] = run && (ra != '0) && busy_q[ra] && !(hit0 || hit1);
`endif
  end

endmodule
